// File: rtl/v_ram_frame_ctrl_if.sv
// Stream-in / stream-out / single-port RAM signal bundle for the frame buffer controller.
// slave is the controller's view; master is the surrounding environment's view.
interface v_ram_frame_ctrl_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 6
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  modport slave (
    input  s_valid, s_data, s_last, m_ready, ram_do,
    output s_ready, m_valid, m_data, m_last, ram_en, ram_we, ram_addr, ram_di
  );

  modport master (
    output s_valid, s_data, s_last, m_ready, ram_do,
    input  s_ready, m_valid, m_data, m_last, ram_en, ram_we, ram_addr, ram_di
  );
endinterface

// File: rtl/v_ram_frame_ctrl.sv
// Store-and-forward frame buffer: fills one frame into an external single-port RAM,
// then drains it in order before accepting the next frame.
module v_ram_frame_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 6
) (
  input logic              clk,
  input logic              rst,
  v_ram_frame_ctrl_if.slave bus
);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q;
  logic [LW-1:0] rd_ptr_q;
  logic [LW-1:0] len_q;
  logic          m_valid_q;
  logic          m_last_q;

  logic          ram_en_c;
  logic          ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [DW-1:0] ram_di_c;
  logic          wr_fire_c;
  logic          frame_end_c;
  logic          rd_fire_c;
  logic          out_done_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // RAM port is driven combinationally so a write or read issues in the handshake cycle
  always_comb begin
    state_d     = state_q;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = wr_ptr_q;
    ram_di_c    = bus.s_data;
    wr_fire_c   = 1'b0;
    frame_end_c = 1'b0;
    rd_fire_c   = 1'b0;
    out_done_c  = 1'b0;
    case (state_q)
      FILL: begin
        if (bus.s_valid) begin
          ram_en_c  = 1'b1;
          ram_we_c  = 1'b1;
          wr_fire_c = 1'b1;
          if (bus.s_last || (wr_ptr_q == '1)) begin
            frame_end_c = 1'b1;
            state_d     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((rd_ptr_q < len_q) && (!m_valid_q || bus.m_ready)) begin
          ram_en_c   = 1'b1;
          ram_addr_c = rd_ptr_q[AW-1:0];
          rd_fire_c  = 1'b1;
        end
        if (m_valid_q && bus.m_ready && m_last_q) begin
          out_done_c = 1'b1;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (rst) begin
      ram_en_c = 1'b0;
      ram_we_c = 1'b0;
    end
  end

  // Pointers, frame length and output flags; m_last tracks the word now held in ram_do
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      len_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      if (wr_fire_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (out_done_c) wr_ptr_q <= '0;
      if (frame_end_c) begin
        len_q    <= LW'(wr_ptr_q) + LW'(1);
        rd_ptr_q <= '0;
      end
      if (rd_fire_c) begin
        rd_ptr_q  <= rd_ptr_q + LW'(1);
        m_valid_q <= 1'b1;
        m_last_q  <= (rd_ptr_q == (len_q - LW'(1)));
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign bus.s_ready  = (state_q == FILL);
  assign bus.m_valid  = m_valid_q;
  assign bus.m_last   = m_last_q;
  assign bus.m_data   = bus.ram_do;
  assign bus.ram_en   = ram_en_c;
  assign bus.ram_we   = ram_we_c;
  assign bus.ram_addr = ram_addr_c;
  assign bus.ram_di   = ram_di_c;
endmodule

// File: tb/tb_v_ram_frame_ctrl.sv
// Randomized bench for v_ram_frame_ctrl: a write-first RAM model plus a frame-level
// scoreboard (per-frame word queue, cycle-count latency rule) checked every cycle.
module tb_v_ram_frame_ctrl;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 6;
  localparam int          DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  v_ram_frame_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  v_ram_frame_ctrl #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Single-port write-first RAM with registered output that holds while disabled
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_di;
        bus.ram_do        <= bus.ram_di;
      end else begin
        bus.ram_do <= mem[bus.ram_addr];
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame-level reference: 0 = collecting a frame, 1 = emitting it
  int            phase = 0;
  logic [DW-1:0] frame_q[$];
  int            out_idx = 0;
  int            cyc = 0;
  int            last_in_cyc = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check_eq("rst_en", 32'(bus.ram_en), 32'd0);
      check_eq("rst_we", 32'(bus.ram_we), 32'd0);
      phase      = 0;
      frame_q.delete();
      out_idx    = 0;
      prev_stall = 1'b0;
    end else if (phase == 0) begin
      check_eq("fill_s_ready", 32'(bus.s_ready), 32'd1);
      check_eq("fill_m_valid", 32'(bus.m_valid), 32'd0);
      check_eq("fill_m_last", 32'(bus.m_last), 32'd0);
      if (bus.s_valid) begin
        check_eq("wr_en", 32'(bus.ram_en), 32'd1);
        check_eq("wr_we", 32'(bus.ram_we), 32'd1);
        check_eq("wr_addr", 32'(bus.ram_addr), 32'(frame_q.size()));
        check_eq("wr_di", 32'(bus.ram_di), 32'(bus.s_data));
        frame_q.push_back(bus.s_data);
        if (bus.s_last || frame_q.size() == DEPTH) begin
          phase       = 1;
          last_in_cyc = cyc;
          out_idx     = 0;
          prev_stall  = 1'b0;
        end
      end else begin
        check_eq("idle_en", 32'(bus.ram_en), 32'd0);
        check_eq("idle_we", 32'(bus.ram_we), 32'd0);
      end
    end else begin
      check_eq("drain_s_ready", 32'(bus.s_ready), 32'd0);
      check_eq("drain_we", 32'(bus.ram_we), 32'd0);
      // First beat two cycles after the last input; continuous afterwards until done
      check_eq("m_valid", 32'(bus.m_valid), 32'((cyc - last_in_cyc) >= 2));
      if (prev_stall) check_eq("stall_data", 32'(bus.m_data), 32'(prev_data));
      if (bus.m_valid) check_eq("m_last", 32'(bus.m_last), 32'(out_idx == frame_q.size() - 1));
      else             check_eq("m_last_idle", 32'(bus.m_last), 32'd0);
      if (bus.m_valid && !bus.m_ready) begin
        check_eq("stall_en", 32'(bus.ram_en), 32'd0);
        prev_stall = 1'b1;
        prev_data  = bus.m_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (out_idx < frame_q.size()) begin
          check_eq("m_data", 32'(bus.m_data), 32'(frame_q[out_idx]));
        end else begin
          check_eq("extra_beat", 32'(out_idx), 32'(frame_q.size() - 1));
        end
        out_idx++;
        if (out_idx >= frame_q.size()) begin
          phase = 0;
          frame_q.delete();
        end
      end
    end
  end

  logic [DW-1:0] src [DEPTH];

  task automatic run_frame(input int n, input bit use_last, input bit rnd_ready,
                           input bit gaps, input int rst_at);
    int beat  = 0;
    int guard = 0;
    while (beat < n && guard < 2000) begin
      bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.s_data  = src[beat];
      bus.s_last  = use_last && (beat == n - 1);
      bus.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) beat++;
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("fill_timeout", 32'(guard < 2000), 32'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    guard = 0;
    while (phase != 0 && guard < 2000) begin
      if (rst_at >= 0 && out_idx >= rst_at) begin
        rst         = 1'b1;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        break;
      end
      bus.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("drain_timeout", 32'(guard < 2000), 32'd1);
    bus.m_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h5A5A;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;

    src[0] = 16'h1111; src[1] = 16'h2222; src[2] = 16'h3333; src[3] = 16'h4444;
    run_frame(4, 1'b1, 1'b0, 1'b0, -1);

    for (int i = 0; i < DEPTH; i++) src[i] = DW'(i);
    run_frame(DEPTH, 1'b0, 1'b0, 1'b0, -1);

    for (int i = 0; i < 8; i++) src[i] = DW'($urandom);
    run_frame(8, 1'b1, 1'b1, 1'b1, -1);

    src[0] = 16'hBEEF;
    run_frame(1, 1'b1, 1'b0, 1'b0, -1);

    for (int i = 0; i < 8; i++) src[i] = DW'($urandom);
    run_frame(8, 1'b1, 1'b0, 1'b0, 3);

    for (int i = 0; i < 5; i++) src[i] = DW'($urandom);
    run_frame(5, 1'b1, 1'b1, 1'b0, -1);

    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++) src[i] = DW'($urandom);
      run_frame(n, (n != DEPTH) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, 1'b1, -1);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/v_ram_frame_ctrl.md
V_RAM_FRAME_CTRL -- requirements
Module: v_ram_frame_ctrl

Interface
REQ-001 Parameter DW, default 16, data width of the stream and of the RAM word.
REQ-002 Parameter AW, default 6, RAM address width; frame capacity is 2^AW words.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 s_valid  in  1  input beat valid.
REQ-007 s_data  in  DW  input beat data.
REQ-008 s_last  in  1  final beat of the input frame.
REQ-009 s_ready  out  1  block accepts an input beat.
REQ-010 m_valid  out  1  output beat valid.
REQ-011 m_data  out  DW  output beat data.
REQ-012 m_last  out  1  final beat of the output frame.
REQ-013 m_ready  in  1  downstream accepts an output beat.
REQ-014 ram_en  out  1  RAM enable, driving single-port write-first RAM en.
REQ-015 ram_we  out  1  RAM write enable.
REQ-016 ram_addr  out  AW  RAM address.
REQ-017 ram_di  out  DW  RAM write data.
REQ-018 ram_do  in  DW  RAM registered read data; holds its value while ram_en=0.

Function
REQ-019 The block SHALL implement two states, FILL and DRAIN; reset state FILL.
REQ-020 In FILL: s_ready=1, m_valid=0.
REQ-021 In FILL, on s_valid&s_ready, the block SHALL drive ram_en=1, ram_we=1, ram_addr=wr_ptr and ram_di=s_data combinationally in the same cycle, then increment wr_ptr.
REQ-022 In FILL, with no handshake: ram_en=0, ram_we=0.
REQ-023 A FILL handshake with s_last=1, or with wr_ptr=2^AW-1, SHALL latch frame length len=wr_ptr+1 (AW+1 bits), clear rd_ptr and enter DRAIN next cycle.
REQ-024 In DRAIN: s_ready=0; ram_we=0 always.
REQ-025 In DRAIN, a read SHALL be issued (ram_en=1, ram_addr=rd_ptr, rd_ptr++) when rd_ptr<len and (m_valid=0 or m_ready=1).
REQ-026 m_valid SHALL be set the cycle after a read issue; it SHALL be cleared after an m_valid&m_ready cycle with no read issued in that cycle.
REQ-027 m_data SHALL equal ram_do directly; no data register in the block.
REQ-028 m_last SHALL be 1 while m_valid=1 and the presented word is address len-1.
REQ-029 On m_valid&m_ready&m_last: enter FILL next cycle, with wr_ptr=0 and m_valid=0.
REQ-030 Latency: the first m_valid SHALL rise 2 cycles after the last input handshake cycle.
REQ-031 Throughput: with m_ready=1 held, one output beat per cycle.
REQ-032 Under backpressure (m_valid=1, m_ready=0), m_data, m_last and m_valid SHALL remain stable and no read SHALL be issued.
REQ-033 Input beats are dropped only by reset; s_ready=0 throughout DRAIN.
REQ-034 A zero-length frame cannot occur; len ranges 1..2^AW.

Reset
REQ-035 When rst=1 at a clock edge: state=FILL, wr_ptr=0, rd_ptr=0, len=0, m_valid=0.
REQ-036 During rst=1, ram_en=0 and ram_we=0 SHALL be forced combinationally.
REQ-037 After reset, s_ready=1 and m_last=0.
REQ-038 Reset mid-FILL or mid-DRAIN SHALL discard the frame; the next frame writes from address 0.

Verification
REQ-039 Reset check: rst=1 for 2 cycles -> s_ready=1, m_valid=0, ram_en=0, ram_we=0.
REQ-040 4-word frame: input 0x1111, 0x2222, 0x3333, 0x4444 with s_last on the 4th, m_ready=1 -> writes to addresses 0..3; m_valid rises 2 cycles after the 4th handshake; four consecutive output beats in order, m_last with 0x4444; s_ready=1 the cycle after.
REQ-041 Full frame: 64 words (value = index), s_last never asserted -> forced end at address 63; 64 output beats; m_last only on 0x003F.
REQ-042 Backpressure: 8-word frame, m_ready toggled pseudo-randomly -> no reads issued while stalled; m_data stable while stalled; all 8 words delivered once, in order.
REQ-043 Single-word frame: 0xBEEF with s_last -> one output beat 0xBEEF, m_last=1.
REQ-044 Reset mid-DRAIN after 3 of 8 beats -> m_valid=0 and s_ready=1 the next cycle; the following frame writes from address 0 and reads back correctly.
